// File: rtl/par2ser_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | par2ser_tx: word-to-bitstream transmitter, one-word holding slot |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module par2ser_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_data,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready
);

  localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [WIDTH-1:0] r_pend, w_pend_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic [c_CW-1:0]  r_cnt, w_cnt_nxt;
  logic             r_pend_valid, w_pend_valid_nxt;
  logic             w_busy, w_accept, w_take, w_done, w_free;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign ser_data  = r_shreg[WIDTH-1];
      assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign ser_data  = r_shreg[0];
      assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
    end
  endgenerate

  assign w_busy    = (r_state == SHIFT);
  assign w_accept  = in_valid & ~r_pend_valid;
  assign w_take    = w_busy & ser_ready;
  assign w_done    = w_take & (r_cnt == c_LAST);
  assign w_free    = ~w_busy | w_done;

  // in_ready is purely registered so it never combinationally follows in_valid/ser_ready
  assign in_ready  = ~r_pend_valid;
  assign ser_valid = w_busy;
  assign ser_last  = w_busy & (r_cnt == c_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shreg      <= '0;
      r_cnt        <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_valid <= w_pend_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_shreg_nxt      = r_shreg;
    w_cnt_nxt        = r_cnt;
    w_pend_nxt       = r_pend;
    w_pend_valid_nxt = r_pend_valid;

    if (w_free && r_pend_valid) begin
      w_shreg_nxt      = r_pend;
      w_pend_valid_nxt = 1'b0;
      w_cnt_nxt        = '0;
      w_state_nxt      = SHIFT;
    end else if (w_free && w_accept) begin
      // Direct load skips the buffer so a free shifter never costs a bubble
      w_shreg_nxt = in_data;
      w_cnt_nxt   = '0;
      w_state_nxt = SHIFT;
    end else begin
      if (w_accept) begin
        w_pend_nxt       = in_data;
        w_pend_valid_nxt = 1'b1;
      end
      if (w_done) begin
        w_state_nxt = IDLE;
      end else if (w_take) begin
        w_cnt_nxt   = r_cnt + c_CW'(1);
        w_shreg_nxt = w_shifted;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_par2ser_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_par2ser_tx: MSB- and LSB-first instances against a word queue |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_par2ser_tx;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             ser_ready;
  logic             m_in_ready, m_ser_data, m_ser_valid, m_ser_last;
  logic             l_in_ready, l_ser_data, l_ser_valid, l_ser_last;

  int n_cmp  = 0;
  int n_fail = 0;

  // Words inside the block in arrival order; idx counts bits of q[0] already taken
  logic [WIDTH-1:0] q[$];
  int               idx = 0;

  always #5 clk = ~clk;

  par2ser_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(m_in_ready),
    .ser_data(m_ser_data), .ser_valid(m_ser_valid), .ser_last(m_ser_last), .ser_ready(ser_ready)
  );

  par2ser_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(l_in_ready),
    .ser_data(l_ser_data), .ser_valid(l_ser_valid), .ser_last(l_ser_last), .ser_ready(ser_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model, cross the rising edge
  task automatic step(input bit iv, input logic [WIDTH-1:0] d, input bit sr, output bit acc);
    logic [WIDTH-1:0] w;
    int               held;
    in_valid  = iv;
    in_data   = d;
    ser_ready = sr;
    @(negedge clk);
    held = q.size();
    chk("in_ready_msb", 64'(m_in_ready), 64'(held < 2));
    chk("in_ready_lsb", 64'(l_in_ready), 64'(held < 2));
    chk("ser_valid_msb", 64'(m_ser_valid), 64'(held > 0));
    chk("ser_valid_lsb", 64'(l_ser_valid), 64'(held > 0));
    if (held > 0) begin
      w = q[0];
      chk("ser_data_msb", 64'(m_ser_data), 64'(w[WIDTH-1-idx]));
      chk("ser_data_lsb", 64'(l_ser_data), 64'(w[idx]));
      chk("ser_last_msb", 64'(m_ser_last), 64'(idx == WIDTH - 1));
      chk("ser_last_lsb", 64'(l_ser_last), 64'(idx == WIDTH - 1));
    end else begin
      chk("ser_last_idle_msb", 64'(m_ser_last), 64'd0);
      chk("ser_last_idle_lsb", 64'(l_ser_last), 64'd0);
    end
    acc = iv && (held < 2);
    if (sr && held > 0) begin
      idx++;
      if (idx == WIDTH) begin
        void'(q.pop_front());
        idx = 0;
      end
    end
    if (acc) q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input bit sr);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) step(1'b1, d, sr, acc);
    chk("send_accepted", 64'(acc), 64'd1);
  endtask

  task automatic drain(input bit random_ready);
    bit acc;
    for (int i = 0; i < 200 && q.size() > 0; i++)
      step(1'b0, '0, random_ready ? 1'($urandom_range(0, 1)) : 1'b1, acc);
    step(1'b0, '0, 1'b1, acc);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid_msb"}, 64'(m_ser_valid), 64'd0);
    chk({tag, "_valid_lsb"}, 64'(l_ser_valid), 64'd0);
    chk({tag, "_data_msb"}, 64'(m_ser_data), 64'd0);
    chk({tag, "_data_lsb"}, 64'(l_ser_data), 64'd0);
    chk({tag, "_last_msb"}, 64'(m_ser_last), 64'd0);
    chk({tag, "_last_lsb"}, 64'(l_ser_last), 64'd0);
    chk({tag, "_ready_msb"}, 64'(m_in_ready), 64'd1);
    chk({tag, "_ready_lsb"}, 64'(l_in_ready), 64'd1);
  endtask

  initial begin
    bit               acc;
    int               oi;
    logic [WIDTH-1:0] offers[3];

    rst = 1'b1; in_valid = 1'b0; in_data = '0; ser_ready = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single words both bit orders, then back-to-back frames
    send(8'hA5, 1'b1); drain(1'b0);
    send(8'h01, 1'b1); drain(1'b0);
    send(8'h01, 1'b1); send(8'h80, 1'b1); drain(1'b0);

    // Buffer fills while the sink stalls
    offers = '{8'h11, 8'h22, 8'h33};
    oi = 0;
    for (int i = 0; i < 80 && (oi < 3 || q.size() > 0); i++) begin
      step(oi < 3, (oi < 3) ? offers[oi] : 8'h00, i >= 6, acc);
      if (acc) oi++;
    end
    chk("backpressure_all_offered", 64'(oi), 64'd3);
    drain(1'b0);

    // Random stalls, then the final bit taken on the same edge as a direct load
    send(8'hC3, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 200 && idx != WIDTH - 1; i++) step(1'b0, '0, 1'($urandom_range(0, 1)), acc);
    step(1'b1, 8'h3C, 1'b1, acc);
    chk("direct_load_on_last", 64'(acc), 64'd1);
    drain(1'b1);

    // Reset in the middle of a frame
    send(8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, acc);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    q.delete();
    idx = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send(8'h0F, 1'b1); drain(1'b0);

    // Random traffic on both sides
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 3) != 0), acc);
    drain(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
